// File: rtl/otp_pkg.sv
// Keystream constants and next-key function shared by the OTP encryptor and decryptor,
// so both ends produce the same keystream.
package otp_pkg;

    localparam logic [15:0] OTP_SEED = 16'h3327;
    localparam logic [15:0] OTP_POLY = 16'hB400;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Galois step: shift right, fold the feedback mask in when the dropped bit is set
    function automatic logic [15:0] otp_next_key(input logic [15:0] key,
                                                 input logic [15:0] poly = OTP_POLY);
        return (key >> 1) ^ (key[0] ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/otp_keystream_lfsr.sv
// 16-bit Galois LFSR keystream generator. Reload to the seed takes priority over advance.
module otp_keystream_lfsr
    import otp_pkg::*;
#(
    parameter logic [15:0] SEED = OTP_SEED,
    parameter logic [15:0] POLY = OTP_POLY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic        reload,
    output logic [15:0] key
);

    logic [15:0] r_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_key <= SEED;
        else if (reload)
            r_key <= SEED;
        else if (advance)
            r_key <= otp_next_key(r_key, POLY);
    end

    assign key = r_key;

endmodule

// File: rtl/otp_stream_decryptor.sv
// Receive-side OTP decryptor: single-stage valid/ready pipe that XORs each ciphertext
// word with the rolling keystream, reseeding at every frame boundary or on resync.
module otp_stream_decryptor
    import otp_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] SEED      = OTP_SEED,
    parameter logic [15:0] POLY      = OTP_POLY,
    parameter int          FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              passthrough,
    input  logic              resync,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       word_count,
    output logic              frame_done
);

    localparam logic [15:0] LP_LAST = 16'(FRAME_LEN - 1);

    out_state_t        r_state;
    out_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [15:0]       r_word_count;
    logic              r_frame_done;
    logic [15:0]       w_key;
    logic              w_accept;
    logic              w_decrypt;
    logic              w_frame_end;

    assign w_accept    = in_valid && in_ready;
    assign w_decrypt   = w_accept && !passthrough;
    assign w_frame_end = w_decrypt && (r_word_count == LP_LAST);

    otp_keystream_lfsr #(
        .SEED (SEED),
        .POLY (POLY)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (w_decrypt),
        .reload  (resync || w_frame_end),
        .key     (w_key)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept)               w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_FULL);
        in_ready  = !out_valid || out_ready;
    end

    // The accepted word always sees the pre-update key, even on resync or frame end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_out_data <= '0;
        else if (w_accept)
            r_out_data <= passthrough ? in_data : (in_data ^ w_key);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (resync || w_frame_end)
                r_word_count <= '0;
            else if (w_decrypt)
                r_word_count <= r_word_count + 16'd1;
        end
    end

    assign out_data   = r_out_data;
    assign word_count = r_word_count;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_otp_stream_decryptor.sv
// Scoreboard bench for otp_stream_decryptor with a short frame (FRAME_LEN = 4).
`timescale 1ns/1ps
module tb_otp_stream_decryptor;

    localparam logic [15:0] T_SEED = 16'h3327;
    localparam logic [15:0] T_POLY = 16'hB400;
    localparam int          T_FLEN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        passthrough = 1'b0;
    logic        resync = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] word_count;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb_q[$];
    logic [15:0] m_key;
    int          m_cnt;
    logic        m_fd;

    always #5 clk = ~clk;

    otp_stream_decryptor #(
        .DATA_W    (16),
        .SEED      (T_SEED),
        .POLY      (T_POLY),
        .FRAME_LEN (T_FLEN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .passthrough (passthrough),
        .resync      (resync),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .word_count  (word_count),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] k);
        logic [15:0] n;
        n = {1'b0, k[15:1]};
        if (k[0]) n = n ^ T_POLY;
        return n;
    endfunction

    // Output side of the scoreboard: pop on every output handshake
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0)
                chk("unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
            else
                chk("out_data", {16'h0, out_data}, {16'h0, sb_q.pop_front()});
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; passthrough = 1'b0; resync = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        m_key = T_SEED; m_cnt = 0; m_fd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        chk("rst_word_count", {16'h0, word_count}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [15:0] d, input logic pt, input logic rs);
        int waited;
        logic [15:0] exp;
        in_data = d; passthrough = pt; resync = rs; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            in_valid = 1'b0; passthrough = 1'b0; resync = 1'b0;
            return;
        end
        m_fd = 1'b0;
        if (pt) begin
            exp = d;
        end else begin
            exp = d ^ m_key;
            m_cnt++;
            if (m_cnt == T_FLEN) begin
                m_cnt = 0; m_key = T_SEED; m_fd = 1'b1;
            end else begin
                m_key = model_step(m_key);
            end
        end
        if (rs) begin
            m_key = T_SEED; m_cnt = 0;
        end
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0; passthrough = 1'b0; resync = 1'b0;
        chk("out_valid_after_accept", {31'h0, out_valid}, 32'h1);
        chk("word_count", {16'h0, word_count}, m_cnt);
        chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    endtask

    initial begin
        // Known keystream head
        chk("key_step1", {16'h0, model_step(T_SEED)}, 32'h0000_AD93);

        // Decryption sequence, back to back
        do_reset();
        send(16'h98EA, 1'b0, 1'b0);
        send(16'h0654, 1'b0, 1'b0);
        send(16'hE2C9, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("seq_drained", {31'h0, out_valid}, 32'h0);

        // Backpressure holds data and key
        do_reset();
        out_ready = 1'b0;
        send(16'h98EA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_out_data", {16'h0, out_data}, 32'h0000_ABCD);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h0654, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Passthrough leaves key and count alone
        do_reset();
        send(16'h1234, 1'b1, 1'b0);
        send(16'h98EA, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Frame boundary at FRAME_LEN = 4, fifth word uses the seed again
        do_reset();
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0);
        send(16'h4444, 1'b0, 1'b0);
        send(16'h98EA, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Resync coincident with the second accept
        do_reset();
        send(16'h98EA, 1'b0, 1'b0);
        send(16'h0654, 1'b0, 1'b1);
        send(16'h98EA, 1'b0, 1'b0);
        chk("resync_count", {16'h0, word_count}, 32'h1);
        @(posedge clk); #1;

        // Reset while a word is held under backpressure
        do_reset();
        out_ready = 1'b0;
        send(16'h98EA, 1'b0, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", {31'h0, out_valid}, 32'h0);
        do_reset();
        send(16'h98EA, 1'b0, 1'b0);
        @(posedge clk); #1;

        chk("queue_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
